video_timing_ctrl: RTL and testbench

//  Programmable raster scheduler in front of the three TMDS encoders. Sequences frames
//  (counters, hSync/vSync, DrawArea) and pulls RGB pixels from an upstream source via a

---
 rtl/video_timing_ctrl_pkg.sv | 42 ++++
 rtl/video_timing_ctrl_axis.sv | 60 ++++++
 rtl/video_timing_ctrl.sv | 154 +++++++++++++++
 tb/tb_video_timing_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_ctrl_pkg.sv
// Shared definitions for the programmable raster scheduler: FSM states,
// timing register addresses and the 640x480@60 power-on timing.
package video_timing_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vtc_state_t;

   localparam logic [2:0] VTC_H_ACTIVE = 3'd0;
   localparam logic [2:0] VTC_H_FP     = 3'd1;
   localparam logic [2:0] VTC_H_SYNC   = 3'd2;
   localparam logic [2:0] VTC_H_BP     = 3'd3;
   localparam logic [2:0] VTC_V_ACTIVE = 3'd4;
   localparam logic [2:0] VTC_V_FP     = 3'd5;
   localparam logic [2:0] VTC_V_SYNC   = 3'd6;
   localparam logic [2:0] VTC_V_BP     = 3'd7;

   localparam int unsigned DEF_H_ACTIVE = 32'd640;
   localparam int unsigned DEF_H_FP     = 32'd16;
   localparam int unsigned DEF_H_SYNC   = 32'd96;
   localparam int unsigned DEF_H_BP     = 32'd48;
   localparam int unsigned DEF_V_ACTIVE = 32'd480;
   localparam int unsigned DEF_V_FP     = 32'd10;
   localparam int unsigned DEF_V_SYNC   = 32'd2;
   localparam int unsigned DEF_V_BP     = 32'd33;

   function automatic int unsigned vtc_default(input logic [2:0] addr);
      case (addr)
         VTC_H_ACTIVE: vtc_default = DEF_H_ACTIVE;
         VTC_H_FP:     vtc_default = DEF_H_FP;
         VTC_H_SYNC:   vtc_default = DEF_H_SYNC;
         VTC_H_BP:     vtc_default = DEF_H_BP;
         VTC_V_ACTIVE: vtc_default = DEF_V_ACTIVE;
         VTC_V_FP:     vtc_default = DEF_V_FP;
         VTC_V_SYNC:   vtc_default = DEF_V_SYNC;
         VTC_V_BP:     vtc_default = DEF_V_BP;
         default:      vtc_default = 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/video_timing_ctrl_axis.sv
// One raster axis: position counter with wrap at total-1 (a zero total behaves
// as one) plus active-window and sync-window compares on the current position.
module video_timing_ctrl_axis #(
   parameter int CW = 10
) (
   input  logic          pixclk,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   input  logic [CW-1:0] active,
   input  logic [CW-1:0] fp,
   input  logic [CW-1:0] sync,
   input  logic [CW-1:0] bp,
   output logic [CW-1:0] pos,
   output logic          wrap,
   output logic          in_active,
   output logic          in_sync
);

   logic [CW-1:0] total_s;
   logic [CW-1:0] last_s;
   logic [CW-1:0] sync_lo_s;
   logic [CW-1:0] sync_hi_s;
   logic [CW-1:0] pos_r;

   // Window boundaries in wrapping CW-bit arithmetic
   always_comb begin
      total_s   = active + fp + sync + bp;
      sync_lo_s = active + fp;
      sync_hi_s = sync_lo_s + sync;
      if (total_s == {CW{1'b0}}) begin
         last_s = {CW{1'b0}};
      end else begin
         last_s = total_s - CW'(1'b1);
      end
   end

   // Position decode; ">=" keeps the counter bounded even if it ever overshoots
   always_comb begin
      wrap      = (pos_r >= last_s);
      in_active = (pos_r < active);
      in_sync   = (pos_r >= sync_lo_s) && (pos_r < sync_hi_s);
   end

   // Position counter
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         pos_r <= {CW{1'b0}};
      end else if (clear) begin
         pos_r <= {CW{1'b0}};
      end else if (advance) begin
         pos_r <= wrap ? {CW{1'b0}} : pos_r + CW'(1'b1);
      end else begin
         pos_r <= pos_r;
      end
   end

   assign pos = pos_r;

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster scheduler: sequences frames, pulls pixels over valid/ready
// and drives registered RGB/DE/syncs to the TMDS encoders.
module video_timing_ctrl
   import video_timing_ctrl_pkg::*;
#(
   parameter int          CW        = 10,
   parameter logic        HSYNC_POL = 1'b1,
   parameter logic        VSYNC_POL = 1'b1,
   parameter logic [23:0] FILL_RGB  = 24'h000000
) (
   input  logic          pixclk,
   input  logic          reset,
   input  logic          enable,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [CW-1:0] cfg_wdata,
   input  logic          pix_valid,
   input  logic [23:0]   pix_data,
   output logic          pix_ready,
   output logic [7:0]    red,
   output logic [7:0]    green,
   output logic [7:0]    blue,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start,
   output logic          underflow,
   input  logic          underflow_clr,
   output logic          busy
);

   vtc_state_t    state_r;
   vtc_state_t    state_nxt_s;
   logic [CW-1:0] shadow_r [8];
   logic [CW-1:0] work_r   [8];
   logic [CW-1:0] cx_s;
   logic [CW-1:0] cy_s;
   logic          h_wrap_s, v_wrap_s;
   logic          h_act_s, v_act_s;
   logic          h_sync_s, v_sync_s;
   logic          run_s, act_s, frame_end_s, load_s, v_adv_s;

   always_comb begin
      run_s       = (state_r == ST_RUN);
      act_s       = run_s & h_act_s & v_act_s;
      frame_end_s = run_s & h_wrap_s & v_wrap_s;
      load_s      = ~run_s | frame_end_s;
      v_adv_s     = run_s & h_wrap_s;
   end

   assign pix_ready = act_s;

   video_timing_ctrl_axis #(.CW(CW)) u_h_axis (
      .pixclk    (pixclk),
      .reset     (reset),
      .clear     (~run_s),
      .advance   (run_s),
      .active    (work_r[VTC_H_ACTIVE]),
      .fp        (work_r[VTC_H_FP]),
      .sync      (work_r[VTC_H_SYNC]),
      .bp        (work_r[VTC_H_BP]),
      .pos       (cx_s),
      .wrap      (h_wrap_s),
      .in_active (h_act_s),
      .in_sync   (h_sync_s)
   );

   video_timing_ctrl_axis #(.CW(CW)) u_v_axis (
      .pixclk    (pixclk),
      .reset     (reset),
      .clear     (~run_s),
      .advance   (v_adv_s),
      .active    (work_r[VTC_V_ACTIVE]),
      .fp        (work_r[VTC_V_FP]),
      .sync      (work_r[VTC_V_SYNC]),
      .bp        (work_r[VTC_V_BP]),
      .pos       (cy_s),
      .wrap      (v_wrap_s),
      .in_active (v_act_s),
      .in_sync   (v_sync_s)
   );

   // Next-state: frames are never truncated, stop only at frame end
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (frame_end_s && !enable) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and busy flag
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s == ST_RUN);
      end
   end

   // Shadow takes writes; working copies the pre-write shadow at frame end or in IDLE
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            shadow_r[i] <= CW'(vtc_default(3'(i)));
            work_r[i]   <= CW'(vtc_default(3'(i)));
         end
      end else begin
         if (cfg_we) begin
            shadow_r[cfg_addr] <= cfg_wdata;
         end
         if (load_s) begin
            for (int i = 0; i < 8; i++) begin
               work_r[i] <= shadow_r[i];
            end
         end
      end
   end

   // Output stage, one cycle behind the counters; an underflow set beats a clear
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         {red, green, blue} <= 24'h000000;
         de          <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         {red, green, blue} <= act_s ? (pix_valid ? pix_data : FILL_RGB) : 24'h000000;
         de          <= act_s;
         hsync       <= (run_s & h_sync_s) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (run_s & v_sync_s) ? VSYNC_POL : ~VSYNC_POL;
         frame_start <= run_s & (cx_s == {CW{1'b0}}) & (cy_s == {CW{1'b0}});
         underflow   <= (act_s & ~pix_valid) ? 1'b1 : (underflow_clr ? 1'b0 : underflow);
      end
   end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomized bench for video_timing_ctrl against a linear-frame-index model,
// plus literal expectations on raster geometry, handshake and reprogramming.
module tb_video_timing_ctrl;

   localparam int          CW   = 10;
   localparam logic [23:0] FILL = 24'h000000;
   localparam int          DEF [8] = '{640, 16, 96, 48, 480, 10, 2, 33};

   logic          pixclk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_addr = 3'd0;
   logic [CW-1:0] cfg_wdata = '0;
   logic          pix_valid = 1'b0;
   logic [23:0]   pix_data = 24'h0;
   logic          underflow_clr = 1'b0;
   logic          pix_ready, de, hsync, vsync, frame_start, underflow, busy;
   logic [7:0]    red, green, blue;

   video_timing_ctrl #(.CW(CW), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FILL_RGB(FILL)) dut (
      .pixclk(pixclk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_ready(pix_ready), .red(red), .green(green),
      .blue(blue), .de(de), .hsync(hsync), .vsync(vsync),
      .frame_start(frame_start), .underflow(underflow),
      .underflow_clr(underflow_clr), .busy(busy)
   );

   always #5 pixclk = ~pixclk;

   int n_vec = 0;
   int n_bad = 0;

   // model: shadow/working config, running flag, linear index inside the frame
   int   sh [8];
   int   wk [8];
   bit   m_run;
   int   m_t;
   bit   m_uf;
   logic e_de, e_hs, e_vs, e_fs, e_busy;
   logic [23:0] e_rgb;
   int   l_x, l_y;
   bit   l_run;

   int fr_cnt = 0, xfer_tot = 0;
   int acc_de = 0, acc_hs = 0, acc_vs = 0, acc_len = 0, acc_rdy = 0;
   int last_de = 0, last_hs = 0, last_vs = 0, last_len = 0, last_rdy = 0;
   bit deflt_phase = 1'b0;
   bit clr_rand = 1'b0;
   int vmode = 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int tot(input int a, input int b, input int c, input int d);
      int s;
      s = (a + b + c + d) % 1024;
      return (s == 0) ? 1 : s;
   endfunction

   function automatic int htot();
      return tot(wk[0], wk[1], wk[2], wk[3]);
   endfunction

   function automatic int vtot();
      return tot(wk[4], wk[5], wk[6], wk[7]);
   endfunction

   function automatic int cur_x();
      return m_t % htot();
   endfunction

   function automatic int cur_y();
      return m_t / htot();
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         sh[i] = DEF[i];
         wk[i] = DEF[i];
      end
      m_run = 1'b0; m_t = 0; m_uf = 1'b0;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      l_run = 1'b0;
   endtask

   task automatic tick();
      int x, y, ht, vt;
      bit act, hs, vs, set;
      pix_data = 24'($urandom);
      case (vmode)
         0:       pix_valid = 1'b0;
         1:       pix_valid = 1'b1;
         default: pix_valid = ($urandom_range(0, 9) != 0);
      endcase
      if (clr_rand) underflow_clr = ($urandom_range(0, 15) == 0);
      #1;
      if (reset) begin
         model_reset();
      end else begin
         ht = htot(); vt = vtot();
         x = m_t % ht; y = m_t / ht;
         act = m_run && (x < wk[0]) && (y < wk[4]);
         hs  = m_run && (x >= (wk[0] + wk[1]) % 1024) && (x < (wk[0] + wk[1] + wk[2]) % 1024);
         vs  = m_run && (y >= (wk[4] + wk[5]) % 1024) && (y < (wk[4] + wk[5] + wk[6]) % 1024);
         chk("pix_ready", pix_ready, act);
         if (pix_valid && pix_ready) xfer_tot++;
         if (pix_ready) acc_rdy++;
         e_de = act; e_hs = hs; e_vs = vs;
         e_rgb = act ? (pix_valid ? pix_data : FILL) : 24'h0;
         e_fs = m_run && (m_t == 0);
         set = act && !pix_valid;
         l_x = x; l_y = y; l_run = m_run;
         if (m_run) begin
            if (m_t == ht * vt - 1) begin
               wk = sh; m_run = enable; m_t = 0;
            end else begin
               m_t++;
            end
         end else begin
            wk = sh;
            if (enable) begin
               m_run = 1'b1; m_t = 0;
            end
         end
         m_uf = set ? 1'b1 : (underflow_clr ? 1'b0 : m_uf);
         if (cfg_we) sh[cfg_addr] = int'(cfg_wdata);
      end
      e_busy = m_run;
      @(posedge pixclk);
      @(negedge pixclk);
      chk("de", de, e_de);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("rgb", {red, green, blue}, e_rgb);
      chk("frame_start", frame_start, e_fs);
      chk("underflow", underflow, m_uf);
      chk("busy", busy, e_busy);
      if (deflt_phase && l_run && l_y == 0) begin
         if (l_x == 639) chk("de_x639", de, 1);
         if (l_x == 640) chk("de_x640", de, 0);
         if (l_x == 655) chk("hs_x655", hsync, 0);
         if (l_x == 656) chk("hs_x656", hsync, 1);
         if (l_x == 751) chk("hs_x751", hsync, 1);
         if (l_x == 752) chk("hs_x752", hsync, 0);
      end
      if (frame_start) begin
         fr_cnt++;
         last_de = acc_de; last_hs = acc_hs; last_vs = acc_vs;
         last_len = acc_len; last_rdy = acc_rdy;
         acc_de = int'(de); acc_hs = int'(hsync); acc_vs = int'(vsync);
         acc_len = 1; acc_rdy = 0;
      end else begin
         acc_de += int'(de); acc_hs += int'(hsync); acc_vs += int'(vsync);
         acc_len++;
      end
      cfg_we = 1'b0;
   endtask

   task automatic run_until(input int tx, input int ty, input int limit);
      int n;
      n = 0;
      while (!(m_run && cur_x() == tx && cur_y() == ty) && n < limit) begin
         tick();
         n++;
      end
      chk("run_until", (m_run && cur_x() == tx && cur_y() == ty), 1);
   endtask

   task automatic wait_frames(input int n, input int limit);
      int target, k;
      target = fr_cnt + n;
      k = 0;
      while (fr_cnt < target && k < limit) begin
         tick();
         k++;
      end
      chk("wait_frames", (fr_cnt >= target), 1);
   endtask

   task automatic cfg_write(input int a, input int d);
      cfg_we = 1'b1;
      cfg_addr = 3'(a);
      cfg_wdata = CW'(d);
      tick();
   endtask

   initial begin
      int snap, k;
      model_reset();
      @(negedge pixclk);
      tick(); tick();
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_busy", busy, 0);
      chk("rst_de", de, 0);
      chk("rst_rgb", {red, green, blue}, 24'h0);

      // default 640x480 raster, handshake and underflow
      reset = 1'b0; enable = 1'b1; vmode = 1; deflt_phase = 1'b1;
      run_until(0, 5, 5000);
      snap = xfer_tot;
      run_until(100, 5, 200);
      vmode = 0;
      tick();
      chk("uf_set", underflow, 1);
      chk("fill_rgb", {red, green, blue}, FILL);
      tick(); tick();
      vmode = 1;
      run_until(0, 6, 900);
      chk("line5_xfer", xfer_tot - snap, 637);
      chk("uf_sticky", underflow, 1);
      deflt_phase = 1'b0;
      vmode = 0; underflow_clr = 1'b1;
      tick();
      chk("uf_set_wins", underflow, 1);
      vmode = 1;
      tick();
      chk("uf_cleared", underflow, 0);
      underflow_clr = 1'b0; vmode = 0;
      tick();
      vmode = 1;
      run_until(300, 6, 400);

      // asynchronous reset mid-frame
      reset = 1'b1; enable = 1'b0;
      #1;
      chk("arst_de", de, 0);
      chk("arst_hsync", hsync, 0);
      chk("arst_busy", busy, 0);
      chk("arst_uf", underflow, 0);
      chk("arst_rgb", {red, green, blue}, 24'h0);
      tick();
      reset = 1'b0;

      // medium raster programmed in IDLE, then small raster written mid-frame
      cfg_write(0, 40); cfg_write(1, 4); cfg_write(2, 6); cfg_write(3, 6);
      cfg_write(4, 20); cfg_write(5, 3); cfg_write(6, 2); cfg_write(7, 5);
      tick();
      enable = 1'b1; vmode = 2; clr_rand = 1'b1;
      wait_frames(1, 10);
      repeat (800) tick();
      cfg_write(0, 4); cfg_write(1, 1); cfg_write(2, 2); cfg_write(3, 1);
      cfg_write(4, 3); cfg_write(5, 1); cfg_write(6, 1); cfg_write(7, 1);
      wait_frames(1, 2000);
      chk("med_len", last_len, 1680);
      chk("med_de", last_de, 800);
      chk("med_hs", last_hs, 180);
      chk("med_vs", last_vs, 112);
      wait_frames(1, 100);
      chk("small_len", last_len, 48);
      chk("small_de", last_de, 12);
      chk("small_hs", last_hs, 12);
      chk("small_vs", last_vs, 8);

      // write landing exactly on the frame-end cycle
      k = 0;
      while (!(m_run && m_t == htot() * vtot() - 1) && k < 100) begin
         tick();
         k++;
      end
      chk("reach_frame_end", (m_run && m_t == htot() * vtot() - 1), 1);
      cfg_write(0, 5);
      wait_frames(2, 200);
      chk("fe_write_len", last_len, 48);
      chk("fe_write_de", last_de, 12);
      wait_frames(1, 200);
      chk("applied_len", last_len, 54);
      chk("applied_de", last_de, 15);

      // enable drop mid-frame, then restart
      run_until(0, 1, 100);
      enable = 1'b0;
      repeat (60) tick();
      chk("stop_busy", busy, 0);
      chk("stop_de", de, 0);
      enable = 1'b1;
      tick();
      chk("restart_busy", busy, 1);
      chk("restart_fs_early", frame_start, 0);
      tick();
      chk("restart_fs", frame_start, 1);

      // zero-width sync, zero active lines
      cfg_write(0, 6); cfg_write(1, 2); cfg_write(2, 0); cfg_write(3, 2);
      cfg_write(4, 4); cfg_write(5, 1); cfg_write(6, 1); cfg_write(7, 1);
      wait_frames(3, 400);
      chk("nosync_hs", last_hs, 0);
      chk("nosync_de", last_de, 24);
      chk("nosync_len", last_len, 70);
      cfg_write(4, 0); cfg_write(2, 3);
      wait_frames(3, 400);
      chk("noact_de", last_de, 0);
      chk("noact_rdy", last_rdy, 0);
      chk("noact_hs", last_hs, 9);
      chk("noact_len", last_len, 39);

      // random small rasters
      repeat (6) begin
         for (int i = 0; i < 8; i++) cfg_write(i, int'($urandom_range(0, 5)));
         wait_frames(3, 2000);
      end

      // all-zero totals collapse to a one-cycle frame
      for (int i = 0; i < 8; i++) cfg_write(i, 0);
      wait_frames(3, 2000);
      chk("zero_len", last_len, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
